soma_endereco_escalonador: RTL and testbench

SOMA_ENDERECO_ESCALONADOR -- requirements
Module: escalonador_proc

---
 rtl/soma_endereco_escalonador.sv | 150 +++++++++++++++
 tb/tb_soma_endereco_escalonador.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/soma_endereco_escalonador.sv
// Two-entry process scheduler: saves/restores PCs and drives id_proc into the address-offset adder.
// Define PREEMPCAO_EN for quantum-based round-robin preemption; otherwise switching is cooperative.
module soma_endereco_escalonador #(
    parameter int unsigned QUANTUM = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       instr_ok,
    input  logic [8:0] pc_atual,
    input  logic       fim_proc,
    input  logic       cria_proc,
    input  logic [1:0] cria_id,
    input  logic [8:0] cria_ender,
    output logic [1:0] id_proc,
    output logic [8:0] pc_novo,
    output logic       carrega_pc,
    output logic       ocupado
);

    typedef enum logic [1:0] {
        StOcioso,
        StExec,
        StSalva,
        StCarrega
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       id_q, id_d;
    // Table index: bit 0 holds id 1, bit 1 holds id 2.
    logic [1:0]       valid_q, valid_d;
    logic [1:0][8:0]  pc_tab_q, pc_tab_d;

    logic             cur_idx;
    logic             cur_valid;
    logic             oth_valid;
    logic [1:0]       oth_id;
    logic             cria_legal;
    logic             cria_idx;
    logic             expira;

    assign cur_idx    = id_q[1];
    assign cur_valid  = valid_q[cur_idx];
    assign oth_valid  = valid_q[~cur_idx];
    assign oth_id     = 2'd3 - id_q;
    assign cria_legal = (cria_id == 2'd1) || (cria_id == 2'd2);
    assign cria_idx   = cria_id[1];

`ifdef PREEMPCAO_EN
    localparam logic [6:0] UltimaInstr = 7'(QUANTUM - 1);

    logic [6:0] cnt_q, cnt_d;

    assign expira = instr_ok && (cnt_q == UltimaInstr);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StCarrega) begin
            cnt_d = '0;
        end else if (state_q == StExec && !fim_proc && instr_ok) begin
            cnt_d = expira ? 7'd0 : cnt_q + 7'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_instr_ok;
    logic unused_quantum;

    assign expira          = 1'b0;
    assign unused_instr_ok = instr_ok;
    assign unused_quantum  = ^7'(QUANTUM);
`endif

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        valid_d  = valid_q;
        pc_tab_d = pc_tab_q;

        case (state_q)
            StOcioso: begin
                if (|valid_q) begin
                    state_d = StCarrega;
                    id_d    = valid_q[0] ? 2'd1 : 2'd2;
                end
            end
            StExec: begin
                if (fim_proc) begin
                    state_d          = StSalva;
                    valid_d[cur_idx] = 1'b0;
                end else if (expira && oth_valid) begin
                    state_d = StSalva;
                end
            end
            StSalva: begin
                if (cur_valid) begin
                    pc_tab_d[cur_idx] = pc_atual;
                end
                if (oth_valid) begin
                    state_d = StCarrega;
                    id_d    = oth_id;
                end else if (cur_valid) begin
                    state_d = StCarrega;
                end else begin
                    state_d = StOcioso;
                    id_d    = 2'd0;
                end
            end
            StCarrega: begin
                state_d = StExec;
            end
            default: begin
                state_d = StOcioso;
                id_d    = 2'd0;
            end
        endcase

        // Gating on valid_q makes a clear by fim_proc win over a same-cycle create.
        if (cria_proc && cria_legal && !valid_q[cria_idx]) begin
            valid_d[cria_idx]  = 1'b1;
            pc_tab_d[cria_idx] = cria_ender;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StOcioso;
            id_q     <= '0;
            valid_q  <= '0;
            pc_tab_q <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            valid_q  <= valid_d;
            pc_tab_q <= pc_tab_d;
        end
    end

    assign id_proc    = id_q;
    assign carrega_pc = (state_q == StCarrega);
    assign ocupado    = (state_q == StSalva) || (state_q == StCarrega);
    assign pc_novo    = carrega_pc ? pc_tab_q[cur_idx] : 9'd0;

endmodule

// File: tb/tb_soma_endereco_escalonador.sv
// Randomized and directed bench for soma_endereco_escalonador against a cycle-level scheduler model.
// Follows PREEMPCAO_EN the same way the design does.
module tb_soma_endereco_escalonador;

    localparam int Quantum = 8;
`ifdef PREEMPCAO_EN
    localparam bit Preempt = 1'b1;
`else
    localparam bit Preempt = 1'b0;
`endif

    localparam int PhIdle = 0;
    localparam int PhRun  = 1;
    localparam int PhSave = 2;
    localparam int PhLoad = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       instr_ok = 1'b0;
    logic [8:0] pc_atual = '0;
    logic       fim_proc = 1'b0;
    logic       cria_proc = 1'b0;
    logic [1:0] cria_id = '0;
    logic [8:0] cria_ender = '0;
    logic [1:0] id_proc;
    logic [8:0] pc_novo;
    logic       carrega_pc;
    logic       ocupado;

    always #5 clock = ~clock;

    soma_endereco_escalonador #(
        .QUANTUM(Quantum)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .instr_ok   (instr_ok),
        .pc_atual   (pc_atual),
        .fim_proc   (fim_proc),
        .cria_proc  (cria_proc),
        .cria_id    (cria_id),
        .cria_ender (cria_ender),
        .id_proc    (id_proc),
        .pc_novo    (pc_novo),
        .carrega_pc (carrega_pc),
        .ocupado    (ocupado)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference scheduler state: phase of the switch protocol, process table, retired count.
    int         m_phase;
    int         m_id;
    int         m_retired;
    logic [2:0] m_v;
    logic [8:0] m_pc [3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = PhIdle;
        m_id      = 0;
        m_retired = 0;
        m_v       = '0;
        for (int k = 0; k < 3; k++) m_pc[k] = '0;
    endtask

    task automatic model_step();
        logic [2:0] ov;
        int other;
        ov    = m_v;
        other = 3 - m_id;
        case (m_phase)
            PhIdle: begin
                if (ov[1] || ov[2]) begin
                    m_phase = PhLoad;
                    m_id    = ov[1] ? 1 : 2;
                end
            end
            PhRun: begin
                if (fim_proc) begin
                    m_v[m_id] = 1'b0;
                    m_phase   = PhSave;
                end else if (instr_ok && Preempt) begin
                    m_retired++;
                    if (m_retired == Quantum) begin
                        m_retired = 0;
                        if (ov[other]) m_phase = PhSave;
                    end
                end
            end
            PhSave: begin
                if (ov[m_id]) m_pc[m_id] = pc_atual;
                if (ov[other]) m_id = other;
                else if (!ov[m_id]) m_id = 0;
                m_phase = (m_id != 0) ? PhLoad : PhIdle;
            end
            default: begin
                m_phase   = PhRun;
                m_retired = 0;
            end
        endcase
        if (cria_proc && (cria_id == 2'd1 || cria_id == 2'd2) && !ov[cria_id]) begin
            m_v[cria_id]  = 1'b1;
            m_pc[cria_id] = cria_ender;
        end
    endtask

    task automatic compare_outputs(input string tag);
        logic [8:0] exp_pc;
        exp_pc = (m_phase == PhLoad) ? m_pc[m_id] : 9'd0;
        check_eq({tag, ".id_proc"}, 32'(id_proc), 32'(m_id));
        check_eq({tag, ".ocupado"}, 32'(ocupado),
                 32'(m_phase == PhSave || m_phase == PhLoad));
        check_eq({tag, ".carrega_pc"}, 32'(carrega_pc), 32'(m_phase == PhLoad));
        check_eq({tag, ".pc_novo"}, 32'(pc_novo), 32'(exp_pc));
    endtask

    task automatic cycle(input logic i, input logic f, input logic c, input logic [1:0] cid,
                         input logic [8:0] cend, input logic [8:0] pca, input string tag);
        instr_ok   = i;
        fim_proc   = f;
        cria_proc  = c;
        cria_id    = cid;
        cria_ender = cend;
        pc_atual   = pca;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_outputs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 9'd0, 9'd0, tag);
    endtask

    task automatic run_instr(input int n, input logic [8:0] pca, input string tag);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 2'd0, 9'd0, pca, tag);
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        compare_outputs("reset");
        reset = 1'b0;

        // First process launch.
        cycle(1'b0, 1'b0, 1'b1, 2'd1, 9'h020, 9'd0, "create1");
        idle(1, "launch1");
        check_eq("launch1.carrega_const", 32'(carrega_pc), 32'd1);
        check_eq("launch1.pc_novo_const", 32'(pc_novo), 32'h020);
        check_eq("launch1.id_const", 32'(id_proc), 32'd1);
        idle(1, "exec1");
        check_eq("exec1.ocupado_const", 32'(ocupado), 32'd0);

        // Lone process never gets switched out on expiry.
        run_instr(Quantum, 9'h028, "lone");
        check_eq("lone.id_const", 32'(id_proc), 32'd1);
        idle(2, "lone_idle");
        check_eq("lone.ocupado_const", 32'(ocupado), 32'd0);

        // Second process plus two quantum expiries.
        cycle(1'b0, 1'b0, 1'b1, 2'd2, 9'h040, 9'h028, "create2");
        run_instr(Quantum, 9'h028, "slice1");
        run_instr(3, 9'h028, "switch1");
        run_instr(Quantum, 9'h044, "slice2");
        run_instr(3, 9'h044, "switch2");

        // Illegal and duplicate creates.
        cycle(1'b0, 1'b0, 1'b1, 2'd0, 9'h1ff, 9'h030, "cria_id0");
        cycle(1'b0, 1'b0, 1'b1, 2'd3, 9'h1ff, 9'h030, "cria_id3");
        cycle(1'b0, 1'b0, 1'b1, 2'd1, 9'h1ff, 9'h030, "cria_dup");
        idle(4, "settle");

        // Two terminations drain the table back to idle.
        cycle(1'b0, 1'b1, 1'b0, 2'd0, 9'd0, 9'h050, "fim_a");
        idle(2, "fim_a_switch");
        cycle(1'b1, 1'b1, 1'b0, 2'd0, 9'd0, 9'h060, "fim_b");
        idle(1, "fim_b_save");
        check_eq("drained.id_const", 32'(id_proc), 32'd0);
        check_eq("drained.ocupado_const", 32'(ocupado), 32'd0);
        idle(3, "drained");

        // Long run with both processes valid.
        cycle(1'b0, 1'b0, 1'b1, 2'd2, 9'h100, 9'd0, "create_b2");
        cycle(1'b0, 1'b0, 1'b1, 2'd1, 9'h0a0, 9'd0, "create_b1");
        idle(3, "long_start");
        for (int k = 0; k < 200; k++) cycle(1'b1, 1'b0, 1'b0, 2'd0, 9'd0, 9'(k), "long");

        // Reset asserted during the load cycle.
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        #2;
        reset = 1'b0;
        @(negedge clock);
        cycle(1'b0, 1'b0, 1'b1, 2'd1, 9'h0c0, 9'd0, "rst_create");
        idle(1, "rst_load");
        check_eq("rst_load.carrega_const", 32'(carrega_pc), 32'd1);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        compare_outputs("rst_async");
        check_eq("rst_async.pc_novo_const", 32'(pc_novo), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        idle(4, "after_rst");
        check_eq("after_rst.carrega_const", 32'(carrega_pc), 32'd0);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
                  9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
